ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the main decoder. Owns the PC and issues single-outstanding requests to instruction memory. Captures each returned word in an instruction register and presents op[5:0] plus the full word to decode through a valid/ready handshake. Accepts jump/branch redirects from the decode/execute side and discards stale in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC and memory address width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address, word aligned
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction word
instr_valid  out  1  instr/op/pc_plus4 valid to decode
instr_ready  in  1  decode accepts instruction
instr  out  32  instruction word
op  out  6  instr[31:26], feeds decoder op input
pc_plus4  out  ADDR_W  address of instr + 4
redirect_valid  in  1  taken branch or jump this cycle
redirect_pc  in  ADDR_W  redirect target

Behaviour:
- Reset (async assert, sync deassert use): pc=RESET_PC, state=REQ, imem_req=0 until first clock after release, instr_valid=0, instr=0, op=0, pc_plus4=0, discard=0.
- States: REQ (imem_req=1, imem_addr=pc), WAIT (request granted, awaiting rvalid), HOLD (instr_valid=1, awaiting instr_ready).
- REQ: imem_gnt -> WAIT. imem_addr stable while imem_req=1 and no gnt.
- WAIT: imem_rvalid and discard=0 -> capture instr=imem_rdata, pc_plus4=pc+4, pc<=pc+4, -> HOLD. imem_rvalid and discard=1 -> drop word, clear discard, -> REQ.
- HOLD: instr_ready -> instr_valid drops next cycle, -> REQ. No new request while HOLD (max one outstanding, one buffered).
- Latency: request issued cycle N, gnt at N, rvalid at N+1 -> instr_valid at N+2. Throughput one instruction per 3 cycles minimum.
- Redirect (highest priority, any state): pc<=redirect_pc with bits[1:0] forced 0. REQ -> stays REQ with new address next cycle (request not granted in same cycle is withdrawn; if gnt coincides, set discard). WAIT -> set discard, stay WAIT (rvalid in same cycle as redirect is also dropped, -> REQ). HOLD -> instr_valid=0 next cycle, -> REQ, held word is dropped even if instr_ready=1 that cycle.
- PC arithmetic: modulo 2^ADDR_W, wraps from all-ones-minus-3 to 0 silently.
- imem_rvalid outside WAIT is ignored.
- reset_n asserted mid-transaction: all state cleared immediately; a late response after release arrives in REQ and is ignored.

Optional Feature:
IFETCH_PERF_EN: when defined, adds outputs perf_fetched[31:0] (words delivered to decode, counted on instr_valid&&instr_ready) and perf_flushed[31:0] (words discarded by redirect), both reset to 0, saturate at all-ones. When undefined, ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: fetch state enum (REQ, WAIT, HOLD), RESET_PC default, op field slice constants (OP_MSB=31, OP_LSB=26), NOP encoding 32'h0000_0000.
- Sub-module ifetch_perf (two saturating counters), instantiated only under IFETCH_PERF_EN. FSM, PC and instruction register stay in ifetch_unit.

Test Plan:
- Reset release, memory gnt immediate, rvalid next cycle with 32'h8C08_0004 -> imem_addr=0, instr_valid 2 cycles after request, op=6'b100011, pc_plus4=4.
- instr_ready held low 5 cycles -> instr/op stable, imem_req=0 throughout; ready high -> next request to address 4.
- Redirect to 32'h0000_0043 while in WAIT, rvalid next cycle -> word dropped, instr_valid stays 0, next imem_addr=32'h0000_0040.
- Redirect coinciding with instr_ready in HOLD -> held word not counted delivered, next fetch from redirect target.
- PC at 32'hFFFF_FFFC, fetch completes -> pc_plus4=0, next imem_addr=0.
- reset_n pulsed low in WAIT, stray rvalid after release -> ignored, first fetch from RESET_PC; with IFETCH_PERF_EN counters read 0.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_unit_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned INSTR_W      = 32;
   localparam int unsigned OP_W         = 6;
   localparam int unsigned OP_MSB       = 31;
   localparam int unsigned OP_LSB       = 26;
   localparam logic [31:0] NOP          = 32'h0000_0000;
   localparam int unsigned PERF_W       = 32;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction memory side, decode handshake and redirect input.
interface ifetch_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [31:0]       imem_rdata;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [5:0]        op;
   logic [ADDR_W-1:0] pc_plus4;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr, instr_valid, instr, op, pc_plus4,
      input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
             redirect_valid, redirect_pc
   );

   // Memory / decode / execute side
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, op, pc_plus4,
      output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ifetch_perf.sv
// Saturating counters for delivered and flushed instruction words.
module ifetch_perf
   import ifetch_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetched_inc,
   input  logic              flushed_inc,
   output logic [PERF_W-1:0] perf_fetched,
   output logic [PERF_W-1:0] perf_flushed
);

   // Count events, holding at all-ones
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (fetched_inc && (perf_fetched != '1))
            perf_fetched <= perf_fetched + PERF_W'(1);
         if (flushed_inc && (perf_flushed != '1))
            perf_flushed <= perf_flushed + PERF_W'(1);
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, instruction
// register with valid/ready to decode, redirect with stale-response discard.
// Optional counters enabled by defining IFETCH_PERF_EN.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset_n,
   ifetch_unit_if.master     bus
`ifdef IFETCH_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_fetched,
   output logic [PERF_W-1:0] perf_flushed
`endif
);

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                discard_q, discard_d;
   logic                req_q;
   logic                valid_q;
   logic [INSTR_W-1:0]  instr_q;
   logic [ADDR_W-1:0]   pc_plus4_q;
   logic                capture;
   logic [ADDR_W-1:0]   redirect_tgt;
   logic [ADDR_W-1:0]   pc_inc;

   assign redirect_tgt = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
   assign pc_inc       = pc_q + ADDR_W'(4);

   // Next-state, next-PC and discard tracking; redirect overrides everything
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      discard_d = discard_q;
      capture   = 1'b0;
      case (state_q)
         ST_REQ: begin
            if (req_q && bus.imem_gnt) begin
               state_d = ST_WAIT;
               // Granted request now targets a stale address
               if (bus.redirect_valid)
                  discard_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (bus.imem_rvalid) begin
               if (discard_q || bus.redirect_valid) begin
                  discard_d = 1'b0;
                  state_d   = ST_REQ;
               end else begin
                  capture = 1'b1;
                  pc_d    = pc_inc;
                  state_d = ST_HOLD;
               end
            end else if (bus.redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (bus.redirect_valid || bus.instr_ready)
               state_d = ST_REQ;
         end
         default: begin
            state_d   = ST_REQ;
            discard_d = 1'b0;
         end
      endcase
      if (bus.redirect_valid)
         pc_d = redirect_tgt;
   end

   // State, PC, registered outputs and instruction register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_REQ;
         pc_q       <= RESET_PC;
         discard_q  <= 1'b0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= NOP;
         pc_plus4_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
         req_q     <= (state_d == ST_REQ);
         valid_q   <= (state_d == ST_HOLD);
         if (capture) begin
            instr_q    <= bus.imem_rdata;
            pc_plus4_q <= pc_inc;
         end
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.instr       = instr_q;
   assign bus.op          = instr_q[OP_MSB:OP_LSB];
   assign bus.pc_plus4    = pc_plus4_q;

`ifdef IFETCH_PERF_EN
   logic fetched_inc;
   logic flushed_inc;

   // Delivered: handshake without a redirect; flushed: any word dropped by redirect
   assign fetched_inc = (state_q == ST_HOLD) && bus.instr_ready && !bus.redirect_valid;
   assign flushed_inc = ((state_q == ST_WAIT) && bus.imem_rvalid &&
                         (discard_q || bus.redirect_valid)) ||
                        ((state_q == ST_HOLD) && bus.redirect_valid);

   ifetch_perf u_perf (
      .clk          (clk),
      .reset_n      (reset_n),
      .fetched_inc  (fetched_inc),
      .flushed_inc  (flushed_inc),
      .perf_fetched (perf_fetched),
      .perf_flushed (perf_flushed)
   );
`endif

endmodule
